// File: rtl/id_stage_if.sv
// Decode-stage bus: F/D inputs, M/W write-back and forwarding inputs,
// next-PC feedback to fetch and the D/E pipeline register outputs.
interface id_stage_if;
  logic [31:0] Instr_D;
  logic [31:0] PC_D;
  logic        stall_D;
  logic        RegWrite_M;
  logic [4:0]  A3_M;
  logic [31:0] WD_M;
  logic        RegWrite_W;
  logic [4:0]  A3_W;
  logic [31:0] WD_W;
  logic        PCsrc_D;
  logic [31:0] NPC;
  logic [4:0]  rs_D;
  logic [4:0]  rt_D;
  logic [31:0] Instr_E;
  logic [31:0] PC_E;
  logic [31:0] RD1_E;
  logic [31:0] RD2_E;
  logic [31:0] EXT_E;

  modport slave (
    input  Instr_D, PC_D, stall_D,
    input  RegWrite_M, A3_M, WD_M,
    input  RegWrite_W, A3_W, WD_W,
    output PCsrc_D, NPC, rs_D, rt_D,
    output Instr_E, PC_E, RD1_E, RD2_E, EXT_E
  );

  modport master (
    output Instr_D, PC_D, stall_D,
    output RegWrite_M, A3_M, WD_M,
    output RegWrite_W, A3_W, WD_W,
    input  PCsrc_D, NPC, rs_D, rt_D,
    input  Instr_E, PC_E, RD1_E, RD2_E, EXT_E
  );
endinterface

// File: rtl/id_stage.sv
// MIPS decode stage: register file with write-through, M/W operand forwarding,
// branch/jump resolution and the D/E pipeline register.
module id_stage #(
  parameter logic [31:0] RESET_PC = 32'h00003000
) (
  input logic       CLK,
  input logic       RESET,
  id_stage_if.slave bus
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  logic [31:0] rf_r [0:31];

  logic [31:0] instr_e_r;
  logic [31:0] pc_e_r;
  logic [31:0] rd1_e_r;
  logic [31:0] rd2_e_r;
  logic [31:0] ext_e_r;

  logic [5:0]  op_s;
  logic [5:0]  funct_s;
  logic [4:0]  rs_s;
  logic [4:0]  rt_s;
  logic [15:0] imm_s;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic [31:0] ext_s;
  logic [31:0] link_s;
  logic [31:0] npc_s;
  logic        pcsrc_s;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // M result beats W write-through, which beats the stored entry; $0 is always zero.
  function automatic logic [31:0] fwd_read(input logic [4:0] addr);
    logic [31:0] val;
    if (addr == 5'd0)
      val = 32'h0000_0000;
    else if (bus.RegWrite_M && (bus.A3_M == addr))
      val = bus.WD_M;
    else if (bus.RegWrite_W && (bus.A3_W == addr))
      val = bus.WD_W;
    else
      val = rf_r[addr];
    return val;
  endfunction

  assign op_s    = bus.Instr_D[31:26];
  assign funct_s = bus.Instr_D[5:0];
  assign rs_s    = bus.Instr_D[25:21];
  assign rt_s    = bus.Instr_D[20:16];
  assign imm_s   = bus.Instr_D[15:0];

  // Operand read with forwarding.
  always_comb begin
    rd1_s = fwd_read(rs_s);
    rd2_s = fwd_read(rt_s);
  end

  // Immediate extension and jal link value.
  always_comb begin
    ext_s  = sext16(imm_s);
    link_s = rd2_s;
    case (op_s)
      OP_ORI:  ext_s = {16'h0000, imm_s};
      OP_LUI:  ext_s = {imm_s, 16'h0000};
      OP_LW,
      OP_SW,
      OP_BEQ:  ext_s = sext16(imm_s);
      default: ext_s = sext16(imm_s);
    endcase
    if (op_s == OP_JAL)
      link_s = bus.PC_D + 32'd8;
    else
      link_s = rd2_s;
  end

  // Next-PC resolution; evaluated regardless of stall.
  always_comb begin
    pcsrc_s = 1'b0;
    npc_s   = bus.PC_D + 32'd4;
    case (op_s)
      OP_BEQ: begin
        pcsrc_s = (rd1_s == rd2_s);
        npc_s   = bus.PC_D + 32'd4 + {{14{imm_s[15]}}, imm_s, 2'b00};
      end
      OP_J,
      OP_JAL: begin
        pcsrc_s = 1'b1;
        npc_s   = {bus.PC_D[31:28], bus.Instr_D[25:0], 2'b00};
      end
      OP_RTYPE: begin
        if (funct_s == FN_JR) begin
          pcsrc_s = 1'b1;
          npc_s   = rd1_s;
        end else begin
          pcsrc_s = 1'b0;
          npc_s   = bus.PC_D + 32'd4;
        end
      end
      default: begin
        pcsrc_s = 1'b0;
        npc_s   = bus.PC_D + 32'd4;
      end
    endcase
  end

  // Register file: cleared on reset, W-port write otherwise ($0 never written).
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < 32; i++)
        rf_r[i] <= 32'h0000_0000;
    end else if (bus.RegWrite_W && (bus.A3_W != 5'd0)) begin
      rf_r[bus.A3_W] <= bus.WD_W;
    end
  end

  // D/E pipeline register: bubble on reset or stall.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      instr_e_r <= 32'h0000_0000;
      pc_e_r    <= RESET_PC;
      rd1_e_r   <= 32'h0000_0000;
      rd2_e_r   <= 32'h0000_0000;
      ext_e_r   <= 32'h0000_0000;
    end else if (bus.stall_D) begin
      instr_e_r <= 32'h0000_0000;
      pc_e_r    <= RESET_PC;
      rd1_e_r   <= 32'h0000_0000;
      rd2_e_r   <= 32'h0000_0000;
      ext_e_r   <= 32'h0000_0000;
    end else begin
      instr_e_r <= bus.Instr_D;
      pc_e_r    <= bus.PC_D;
      rd1_e_r   <= rd1_s;
      rd2_e_r   <= link_s;
      ext_e_r   <= ext_s;
    end
  end

  assign bus.PCsrc_D = pcsrc_s;
  assign bus.NPC     = npc_s;
  assign bus.rs_D    = rs_s;
  assign bus.rt_D    = rt_s;
  assign bus.Instr_E = instr_e_r;
  assign bus.PC_E    = pc_e_r;
  assign bus.RD1_E   = rd1_e_r;
  assign bus.RD2_E   = rd2_e_r;
  assign bus.EXT_E   = ext_e_r;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: register file, forwarding, extension,
// next-PC resolution, stall bubbles and reset.
module tb_id_stage;

  logic CLK;
  logic RESET;
  int   checks;
  int   errors;

  id_stage_if bus ();

  id_stage #(.RESET_PC(32'h00003000)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    bus.RegWrite_W = 1'b1;
    bus.A3_W       = a;
    bus.WD_W       = d;
    tick();
    bus.RegWrite_W = 1'b0;
    bus.A3_W       = 5'd0;
    bus.WD_W       = 32'h0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    RESET          = 1'b1;
    bus.Instr_D    = 32'h00221821;
    bus.PC_D       = 32'h00003004;
    bus.stall_D    = 1'b0;
    bus.RegWrite_M = 1'b0;
    bus.A3_M       = 5'd0;
    bus.WD_M       = 32'h0;
    bus.RegWrite_W = 1'b1;
    bus.A3_W       = 5'd1;
    bus.WD_W       = 32'hDEADBEEF;

    // Reset edge: bubble; the $1 write in this cycle is discarded
    tick();
    check("rst_instr_e", bus.Instr_E, 32'h00000000);
    check("rst_pc_e",    bus.PC_E,    32'h00003000);
    check("rst_rd1_e",   bus.RD1_E,   32'h00000000);
    check("rst_rd2_e",   bus.RD2_E,   32'h00000000);
    check("rst_ext_e",   bus.EXT_E,   32'h00000000);
    check("rs_d",        {27'd0, bus.rs_D}, 32'd1);
    check("rt_d",        {27'd0, bus.rt_D}, 32'd2);

    RESET = 1'b0;
    bus.RegWrite_W = 1'b0;
    bus.A3_W       = 5'd0;
    bus.WD_W       = 32'h0;
    tick();
    check("post_rst_instr_e", bus.Instr_E, 32'h00221821);
    check("post_rst_pc_e",    bus.PC_E,    32'h00003004);
    check("post_rst_rd1_e",   bus.RD1_E,   32'h00000000);
    check("post_rst_rd2_e",   bus.RD2_E,   32'h00000000);

    // Write-through: W writes $5 while ori $6,$5,0x00FF is in D
    bus.Instr_D    = 32'h34A600FF;
    bus.PC_D       = 32'h00003008;
    bus.RegWrite_W = 1'b1;
    bus.A3_W       = 5'd5;
    bus.WD_W       = 32'h12345678;
    tick();
    check("wt_rd1_e", bus.RD1_E, 32'h12345678);
    check("wt_ext_e", bus.EXT_E, 32'h000000FF);
    bus.RegWrite_W = 1'b0;
    tick();
    check("stored_rd1_e", bus.RD1_E, 32'h12345678);

    // Write to $0 must not stick or pass through
    bus.Instr_D    = 32'h00001821;
    bus.RegWrite_W = 1'b1;
    bus.A3_W       = 5'd0;
    bus.WD_W       = 32'hFFFFFFFF;
    tick();
    check("r0_wt_rd1_e", bus.RD1_E, 32'h00000000);
    bus.RegWrite_W = 1'b0;
    tick();
    check("r0_rd1_e", bus.RD1_E, 32'h00000000);

    // beq $1,$2,-2 with $1 forwarded from M
    write_reg(5'd1, 32'd7);
    write_reg(5'd2, 32'd9);
    bus.Instr_D    = 32'h1022FFFE;
    bus.PC_D       = 32'h00003010;
    bus.RegWrite_M = 1'b1;
    bus.A3_M       = 5'd1;
    bus.WD_M       = 32'd9;
    #1;
    check("beq_fwd_pcsrc", {31'd0, bus.PCsrc_D}, 32'd1);
    check("beq_fwd_npc",   bus.NPC, 32'h0000300C);
    bus.RegWrite_M = 1'b0;
    #1;
    check("beq_nofwd_pcsrc", {31'd0, bus.PCsrc_D}, 32'd0);
    check("beq_nofwd_npc",   bus.NPC, 32'h0000300C);
    tick();
    check("beq_ext_e", bus.EXT_E, 32'hFFFFFFFE);
    check("beq_rd1_e", bus.RD1_E, 32'd7);

    // j / jal
    bus.Instr_D = 32'h08000C04;
    bus.PC_D    = 32'h00003000;
    #1;
    check("j_pcsrc", {31'd0, bus.PCsrc_D}, 32'd1);
    check("j_npc",   bus.NPC, 32'h00003010);
    bus.Instr_D = 32'h0C000C10;
    bus.PC_D    = 32'h00003004;
    #1;
    check("jal_npc", bus.NPC, 32'h00003040);
    tick();
    check("jal_rd2_e",   bus.RD2_E,   32'h0000300C);
    check("jal_instr_e", bus.Instr_E, 32'h0C000C10);

    // jr $31: from file, W write-through, then M over W
    write_reg(5'd31, 32'h00003040);
    bus.Instr_D = 32'h03E00008;
    bus.PC_D    = 32'h00003050;
    #1;
    check("jr_pcsrc", {31'd0, bus.PCsrc_D}, 32'd1);
    check("jr_npc",   bus.NPC, 32'h00003040);
    bus.RegWrite_W = 1'b1;
    bus.A3_W       = 5'd31;
    bus.WD_W       = 32'h00006000;
    #1;
    check("jr_w_npc", bus.NPC, 32'h00006000);
    bus.RegWrite_M = 1'b1;
    bus.A3_M       = 5'd31;
    bus.WD_M       = 32'h00005000;
    #1;
    check("jr_m_over_w_npc", bus.NPC, 32'h00005000);
    bus.RegWrite_M = 1'b0;
    bus.RegWrite_W = 1'b0;
    bus.A3_M       = 5'd0;
    bus.A3_W       = 5'd0;

    // Stall bubble with lw in D, then release
    bus.stall_D = 1'b1;
    bus.Instr_D = 32'h8C220004;
    bus.PC_D    = 32'h00003008;
    #1;
    check("lw_pcsrc", {31'd0, bus.PCsrc_D}, 32'd0);
    check("lw_npc",   bus.NPC, 32'h0000300C);
    tick();
    check("stall_instr_e", bus.Instr_E, 32'h00000000);
    check("stall_pc_e",    bus.PC_E,    32'h00003000);
    check("stall_ext_e",   bus.EXT_E,   32'h00000000);
    check("stall_rd1_e",   bus.RD1_E,   32'h00000000);
    bus.stall_D = 1'b0;
    tick();
    check("unstall_instr_e", bus.Instr_E, 32'h8C220004);
    check("unstall_pc_e",    bus.PC_E,    32'h00003008);
    check("unstall_ext_e",   bus.EXT_E,   32'h00000004);
    check("unstall_rd1_e",   bus.RD1_E,   32'd7);

    // Extension variants
    bus.Instr_D = 32'h3C018001;
    tick();
    check("lui_ext_e", bus.EXT_E, 32'h80010000);
    bus.Instr_D = 32'hAC22FFFC;
    tick();
    check("sw_ext_e", bus.EXT_E, 32'hFFFFFFFC);
    check("sw_rd2_e", bus.RD2_E, 32'd9);
    bus.Instr_D = 32'h34018000;
    tick();
    check("ori_zext_e", bus.EXT_E, 32'h00008000);

    // Reset mid-stream clears the file and bubbles D/E
    bus.Instr_D = 32'h34A600FF;
    bus.PC_D    = 32'h00003020;
    RESET = 1'b1;
    tick();
    check("mid_rst_instr_e", bus.Instr_E, 32'h00000000);
    check("mid_rst_rd1_e",   bus.RD1_E,   32'h00000000);
    check("mid_rst_pc_e",    bus.PC_E,    32'h00003000);
    RESET = 1'b0;
    tick();
    check("after_rst_instr_e", bus.Instr_E, 32'h34A600FF);
    check("after_rst_rd1_e",   bus.RD1_E,   32'h00000000);
    check("after_rst_ext_e",   bus.EXT_E,   32'h000000FF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage MIPS pipeline, directly downstream of the fetch unit. Consumes the F/D register outputs (`Instr_D`, `PC_D`) and hosts the 32×32 general register file. Resolves branches and jumps in D, returning `PCsrc_D`/`NPC` to fetch. Drives the D/E pipeline register with operands, extended immediate and link data.

## Interface
Parameters:
- `RESET_PC`, 32'h00003000: value loaded into `PC_E` on reset/bubble.

Ports:
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `Instr_D`  in  32  instruction in D, from the F/D register.
- `PC_D`  in  32  PC of `Instr_D`.
- `stall_D`  in  1  from the hazard unit. Fetch freezes F and D; this block loads a bubble into D/E.
- `RegWrite_M`, `A3_M`, `WD_M`  in  1/5/32  M-stage write intent, destination and result (forward source).
- `RegWrite_W`, `A3_W`, `WD_W`  in  1/5/32  W-stage register-file write port.
- `PCsrc_D`  out  1  1 = fetch takes `NPC`.
- `NPC`  out  32  jump/branch target.
- `rs_D`, `rt_D`  out  5  `Instr_D[25:21]` and `Instr_D[20:16]`, for the hazard unit.
- `Instr_E`, `PC_E`, `RD1_E`, `RD2_E`, `EXT_E`  out  32 each  D/E register outputs.

## Operation
- Supported opcodes / functs:
  - R-type (op 000000): addu 100001, subu 100011, jr 001000.
  - I-type: ori 001101, lw 100011, sw 101011, beq 000100, lui 001111.
  - J-type: j 000010, jal 000011.
  - Any other encoding behaves as nop: no jump, normal register-file reads.
- Register file:
  - 32 × 32 bits.
  - Write at posedge when `RegWrite_W && A3_W != 0`.
  - `$0` reads 0 and is never written.
  - Write-through: a same-cycle read of `A3_W` (nonzero, `RegWrite_W` = 1) returns `WD_W`.
- Operand forwarding (`RD1`/`RD2` from rs/rt):
  - If `RegWrite_M && A3_M != 0 && A3_M == addr`, use `WD_M`.
  - Otherwise use the register-file read, including write-through.
  - M takes priority over W.
- Extension into `EXT_E`:
  - ori: zero-extend imm16.
  - lw/sw/beq: sign-extend.
  - lui: `{imm16, 16'h0}`.
  - Otherwise: sign-extend.
- Next PC:
  - beq: `PCsrc_D` = (fwd rs == fwd rt); `NPC` = `PC_D + 4 + (sext(imm16) << 2)`.
  - j/jal: `PCsrc_D` = 1; `NPC` = `{PC_D[31:28], Instr_D[25:0], 2'b00}`.
  - jr: `PCsrc_D` = 1; `NPC` = forwarded rs.
  - Otherwise: `PCsrc_D` = 0; `NPC` = `PC_D + 4`.
  - The delay slot is always executed; this block never flushes F/D.
- jal link:
  - `RD2_E` carries `PC_D + 8`.
  - The destination (31) is decoded downstream from `Instr_E`.
- `PCsrc_D`/`NPC` are combinational and computed even while `stall_D` = 1. Fetch ignores them while `stall_F` = 1.

## Timing
- Decode, register read, forwarding and next-PC logic are combinational within the D cycle.
- D/E register, at posedge:
  - `RESET` = 1: load `Instr_E` = 0, `PC_E` = `RESET_PC`, `RD1_E` = `RD2_E` = `EXT_E` = 0.
  - else `stall_D` = 1: load the same bubble values.
  - else: load decoded values from the current D instruction.
- Register file on `RESET`: all 32 entries cleared in the same edge. A write requested in the reset cycle is discarded.
- Latency: `Instr_D` present at cycle n appears on `Instr_E` after edge n+1.
- Reset mid-stream: outputs hold bubble values from the first edge with `RESET` high. Normal decode resumes on the first edge after `RESET` falls.
- Simultaneous W write and D read of the same register: the read sees the new value (write-through). The stored value updates at the same edge.

## Test plan
- Reset, then read: assert `RESET` 1 cycle; `Instr_D` = `addu $3,$1,$2` (32'h00221821) → `RD1_E` = `RD2_E` = 0, `PC_E` = 32'h00003000 on the reset edge; 0 again the next edge.
- Write-through: W writes `$5` = 32'h12345678; same cycle `Instr_D` = `ori $6,$5,0x00FF` → `RD1_E` = 32'h12345678, `EXT_E` = 32'h000000FF. Write to `$0` → `$0` still reads 0.
- M forwarding beq: `$1` holds 7 in the file; `A3_M` = 1, `WD_M` = 9, `RegWrite_M` = 1; `$2` = 9; beq `$1,$2,-2` at `PC_D` = 32'h3010 → `PCsrc_D` = 1, `NPC` = 32'h300C. With `RegWrite_M` = 0 → `PCsrc_D` = 0.
- Jumps:
  - j with `PC_D` = 32'h3000, index 0xC04 → `NPC` = 32'h3010, `PCsrc_D` = 1.
  - jal at 32'h3004 → `RD2_E` = 32'h300C after the edge.
  - jr `$31` with `$31` = 32'h3040 → `NPC` = 32'h3040.
- Stall bubble: `stall_D` = 1 with `Instr_D` = lw (32'h8C220004) → `Instr_E` = 0, `PC_E` = 32'h3000. Release `stall_D` → next edge `Instr_E` = 32'h8C220004, `EXT_E` = 4.
- Extension: lui `$1`,0x8001 → `EXT_E` = 32'h80010000. sw with imm 0xFFFC → `EXT_E` = 32'hFFFFFFFC.
